// File: rtl/decode_pkg.sv
`timescale 1ns/1ps
// decode_pkg
// Shared constants for the decode / operand-fetch stage:
//   - data, opcode, register-address and instruction widths
//   - bit positions of each instruction field
//   - decoded-instruction struct and the source-operand resolution helper
package decode_pkg;

    localparam int DATA_W   = 8;
    localparam int OP_W     = 5;
    localparam int REG_AW   = 3;
    localparam int INSTR_W  = 24;
    localparam int NUM_REGS = 1 << REG_AW;

    localparam int OP_HI      = 23;
    localparam int OP_LO      = 19;
    localparam int RD_HI      = 18;
    localparam int RD_LO      = 16;
    localparam int RS_HI      = 15;
    localparam int RS_LO      = 13;
    localparam int IMM_EN_BIT = 12;
    localparam int RT_HI      = 11;
    localparam int RT_LO      = 9;
    localparam int WE_BIT     = 8;
    localparam int IMM_HI     = 7;
    localparam int IMM_LO     = 0;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic              imm_en;
        logic [REG_AW-1:0] rt;
        logic              we;
        logic [DATA_W-1:0] imm8;
    } instr_fields_t;

    function automatic instr_fields_t split_instr(input logic [INSTR_W-1:0] word);
        instr_fields_t f;
        f.op     = word[OP_HI:OP_LO];
        f.rd     = word[RD_HI:RD_LO];
        f.rs     = word[RS_HI:RS_LO];
        f.imm_en = word[IMM_EN_BIT];
        f.rt     = word[RT_HI:RT_LO];
        f.we     = word[WE_BIT];
        f.imm8   = word[IMM_HI:IMM_LO];
        return f;
    endfunction

    // Priority: r0 is always zero, then the result still sitting in EX,
    // then the value being written back this cycle, then the register file.
    function automatic logic [DATA_W-1:0] resolve_src(
        input logic [REG_AW-1:0] src,
        input logic              ex_valid,
        input logic              ex_wr,
        input logic [REG_AW-1:0] ex_rd,
        input logic [DATA_W-1:0] ex_val,
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data,
        input logic [DATA_W-1:0] rf_val
    );
        if (src == '0)
            return '0;
        else if (ex_valid && ex_wr && (ex_rd == src))
            return ex_val;
        else if (wb_en && (wb_addr == src))
            return wb_data;
        else
            return rf_val;
    endfunction

endpackage

// File: rtl/reg_file_8x8.sv
`timescale 1ns/1ps
// reg_file_8x8
// Eight 8-bit registers, r0 hardwired to zero.
// Ports:
//   clk, reset (async, active-low clear of every register)
//   rd_addr_a / rd_data_a : asynchronous read port A
//   rd_addr_b / rd_data_b : asynchronous read port B
//   wr_en, wr_addr, wr_data : synchronous write port (writes to r0 dropped)
module reg_file_8x8
    import decode_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // r0 storage is cleared by reset and never written, so it stays zero;
    // the read muxes also force zero so r0 cannot depend on that cell.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/decode_block.sv
`timescale 1ns/1ps
// decode_block
// Instruction decode / operand fetch stage feeding ExecutionBlock.
// Ports:
//   clk, reset (async, active-low)
//   instr_valid, instr        : incoming 24-bit instruction
//   instr_ready               : stage accepts an instruction (= !stall)
//   stall                     : downstream hold request
//   wb_en, wb_addr, wb_data   : writeback port into the register file
//   ans_ex                    : current EX result, used for forwarding
//   A, B, data_in, op_dec     : registered operands/opcode to EX
//   rd_ex, wr_ex, valid_ex    : destination info of the instruction in EX
module decode_block
    import decode_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    input  logic               stall,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic [DATA_W-1:0]  ans_ex,
    output logic [DATA_W-1:0]  A,
    output logic [DATA_W-1:0]  B,
    output logic [DATA_W-1:0]  data_in,
    output logic [OP_W-1:0]    op_dec,
    output logic [REG_AW-1:0]  rd_ex,
    output logic               wr_ex,
    output logic               valid_ex
);

    instr_fields_t     fields;
    logic [DATA_W-1:0] rf_rs;
    logic [DATA_W-1:0] rf_rt;
    logic [DATA_W-1:0] val_rs;
    logic [DATA_W-1:0] val_rt;

    assign fields      = split_instr(instr);
    assign instr_ready = !stall;

    reg_file_8x8 u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (fields.rs),
        .rd_data_a (rf_rs),
        .rd_addr_b (fields.rt),
        .rd_data_b (rf_rt),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data)
    );

    // Forwarding compares against the EX register as it stands before the
    // edge, so a dependent instruction directly behind a writer needs no stall.
    always_comb begin
        val_rs = resolve_src(fields.rs, valid_ex, wr_ex, rd_ex, ans_ex,
                             wb_en, wb_addr, wb_data, rf_rs);
        val_rt = resolve_src(fields.rt, valid_ex, wr_ex, rd_ex, ans_ex,
                             wb_en, wb_addr, wb_data, rf_rt);
    end

    // EX pipeline register. A bubble only clears the valid/write flags;
    // the operand fields keep their old values since EX ignores them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            A        <= '0;
            B        <= '0;
            data_in  <= '0;
            op_dec   <= '0;
            rd_ex    <= '0;
            wr_ex    <= 1'b0;
            valid_ex <= 1'b0;
        end else if (!stall) begin
            if (instr_valid) begin
                A        <= val_rs;
                B        <= fields.imm_en ? fields.imm8 : val_rt;
                data_in  <= val_rt;
                op_dec   <= fields.op;
                rd_ex    <= fields.rd;
                wr_ex    <= fields.we && (fields.rd != '0);
                valid_ex <= 1'b1;
            end else begin
                wr_ex    <= 1'b0;
                valid_ex <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_block.sv
`timescale 1ns/1ps
// tb_decode_block
// Scoreboarded directed test: each stimulus cycle pushes the hand-computed
// EX-register contents expected after the following rising edge; a monitor
// pops one entry per cycle and compares it with the DUT outputs.
module tb_decode_block;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [23:0] instr;
    logic        instr_ready;
    logic        stall;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [7:0]  wb_data;
    logic [7:0]  ans_ex;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [7:0]  data_in;
    logic [4:0]  op_dec;
    logic [2:0]  rd_ex;
    logic        wr_ex;
    logic        valid_ex;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic [4:0] op;
        logic [2:0] rd;
        logic       wr;
        logic       valid;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   tag_q[$];
    int   vec_id      = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    decode_block dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .stall       (stall),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .ans_ex      (ans_ex),
        .A           (A),
        .B           (B),
        .data_in     (data_in),
        .op_dec      (op_dec),
        .rd_ex       (rd_ex),
        .wr_ex       (wr_ex),
        .valid_ex    (valid_ex)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic ie,
                                       input logic [2:0] rt, input logic we,
                                       input logic [7:0] imm);
        return {op, rd, rs, ie, rt, we, imm};
    endfunction

    function automatic exp_t ex(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] d, input logic [4:0] op,
                                input logic [2:0] rd, input logic wr,
                                input logic v, input logic rdy);
        exp_t e;
        e = {a, b, d, op, rd, wr, v, rdy};
        return e;
    endfunction

    task automatic checkOutput(input string name, input exp_t e);
        exp_t act;
        act = {A, B, data_in, op_dec, rd_ex, wr_ex, valid_ex, instr_ready};
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("[TB] FAIL %s: got A=%h B=%h d=%h op=%h rd=%0d wr=%b v=%b rdy=%b, expected A=%h B=%h d=%h op=%h rd=%0d wr=%b v=%b rdy=%b",
                     name, act.a, act.b, act.d, act.op, act.rd, act.wr, act.valid, act.ready,
                     e.a, e.b, e.d, e.op, e.rd, e.wr, e.valid, e.ready);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [23:0] ins,
                                 input logic st, input logic wbe,
                                 input logic [2:0] wa, input logic [7:0] wd,
                                 input logic [7:0] ax, input exp_t e);
        @(negedge clk);
        instr_valid = iv;
        instr       = ins;
        stall       = st;
        wb_en       = wbe;
        wb_addr     = wa;
        wb_data     = wd;
        ans_ex      = ax;
        exp_q.push_back(e);
        tag_q.push_back(vec_id);
        vec_id++;
    endtask

    task automatic idleInputs();
        instr_valid = 1'b0;
        instr       = '0;
        stall       = 1'b0;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        ans_ex      = '0;
    endtask

    // Monitor: one expected entry corresponds to one rising edge
    initial begin
        exp_t e;
        int   t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checkOutput($sformatf("vec%0d", t), e);
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idleInputs();
        reset = 1'b0;
        #7;
        checkOutput("reset_state", ex(8'h00, 8'h00, 8'h00, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        reset = 1'b1;

        // Load r4=C0 then r3=40 with no instruction: bubbles hold reset values
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 3'd4, 8'hC0, 8'h00,
                      ex(8'h00, 8'h00, 8'h00, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1));
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 3'd3, 8'h40, 8'h00,
                      ex(8'h00, 8'h00, 8'h00, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1));
        // Register operands
        applyStimulus(1'b1, mk(5'd0, 3'd1, 3'd3, 1'b0, 3'd4, 1'b0, 8'h00), 1'b0, 1'b0, 3'd0, 8'h00, 8'h00,
                      ex(8'h40, 8'hC0, 8'hC0, 5'd0, 3'd1, 1'b0, 1'b1, 1'b1));
        // Immediate B, data_in still r4
        applyStimulus(1'b1, mk(5'd2, 3'd2, 3'd3, 1'b1, 3'd4, 1'b0, 8'h08), 1'b0, 1'b0, 3'd0, 8'h00, 8'h00,
                      ex(8'h40, 8'h08, 8'hC0, 5'd2, 3'd2, 1'b0, 1'b1, 1'b1));
        // I1 writes r5
        applyStimulus(1'b1, mk(5'd1, 3'd5, 3'd3, 1'b0, 3'd0, 1'b1, 8'h00), 1'b0, 1'b0, 3'd0, 8'h00, 8'h00,
                      ex(8'h40, 8'h00, 8'h00, 5'd1, 3'd5, 1'b1, 1'b1, 1'b1));
        // I2 reads r5: forwarded from EX
        applyStimulus(1'b1, mk(5'd3, 3'd6, 3'd5, 1'b0, 3'd4, 1'b0, 8'h00), 1'b0, 1'b0, 3'd0, 8'h00, 8'h77,
                      ex(8'h77, 8'hC0, 8'hC0, 5'd3, 3'd6, 1'b0, 1'b1, 1'b1));
        // rd=5 but we=0, while r5 gets 22 via writeback
        applyStimulus(1'b1, mk(5'd4, 3'd5, 3'd3, 1'b0, 3'd4, 1'b0, 8'h00), 1'b0, 1'b1, 3'd5, 8'h22, 8'h00,
                      ex(8'h40, 8'hC0, 8'hC0, 5'd4, 3'd5, 1'b0, 1'b1, 1'b1));
        // No forward since wr_ex=0: register contents
        applyStimulus(1'b1, mk(5'd5, 3'd7, 3'd5, 1'b0, 3'd0, 1'b0, 8'h00), 1'b0, 1'b0, 3'd0, 8'h00, 8'h77,
                      ex(8'h22, 8'h00, 8'h00, 5'd5, 3'd7, 1'b0, 1'b1, 1'b1));
        // Same-cycle writeback bypass
        applyStimulus(1'b1, mk(5'd6, 3'd1, 3'd5, 1'b0, 3'd4, 1'b0, 8'h00), 1'b0, 1'b1, 3'd5, 8'h11, 8'h77,
                      ex(8'h11, 8'hC0, 8'hC0, 5'd6, 3'd1, 1'b0, 1'b1, 1'b1));
        // Writer of r5 again
        applyStimulus(1'b1, mk(5'd1, 3'd5, 3'd0, 1'b0, 3'd0, 1'b1, 8'h00), 1'b0, 1'b0, 3'd0, 8'h00, 8'h00,
                      ex(8'h00, 8'h00, 8'h00, 5'd1, 3'd5, 1'b1, 1'b1, 1'b1));
        // EX forward beats a concurrent writeback to the same register (both sources)
        applyStimulus(1'b1, mk(5'd7, 3'd2, 3'd5, 1'b0, 3'd5, 1'b0, 8'h00), 1'b0, 1'b1, 3'd5, 8'h33, 8'h55,
                      ex(8'h55, 8'h55, 8'h55, 5'd7, 3'd2, 1'b0, 1'b1, 1'b1));
        // r0: write FF discarded and bypass ignored; rd=0 with we=1 gives wr_ex=0
        applyStimulus(1'b1, mk(5'd8, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 8'h00), 1'b0, 1'b1, 3'd0, 8'hFF, 8'h00,
                      ex(8'h00, 8'h00, 8'h00, 5'd8, 3'd0, 1'b0, 1'b1, 1'b1));
        applyStimulus(1'b1, mk(5'd9, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00), 1'b0, 1'b0, 3'd0, 8'h00, 8'hAA,
                      ex(8'h00, 8'h00, 8'h00, 5'd9, 3'd3, 1'b0, 1'b1, 1'b1));
        // Establish EX contents before the stall
        applyStimulus(1'b1, mk(5'd10, 3'd4, 3'd3, 1'b0, 3'd5, 1'b1, 8'h00), 1'b0, 1'b0, 3'd0, 8'h00, 8'h00,
                      ex(8'h40, 8'h33, 8'h33, 5'd10, 3'd4, 1'b1, 1'b1, 1'b1));
        // Three stalled cycles with new instructions offered; r6 written meanwhile
        applyStimulus(1'b1, mk(5'd31, 3'd7, 3'd1, 1'b0, 3'd1, 1'b1, 8'h00), 1'b1, 1'b1, 3'd6, 8'h99, 8'h00,
                      ex(8'h40, 8'h33, 8'h33, 5'd10, 3'd4, 1'b1, 1'b1, 1'b0));
        applyStimulus(1'b1, mk(5'd31, 3'd7, 3'd1, 1'b0, 3'd1, 1'b1, 8'h00), 1'b1, 1'b0, 3'd0, 8'h00, 8'h00,
                      ex(8'h40, 8'h33, 8'h33, 5'd10, 3'd4, 1'b1, 1'b1, 1'b0));
        applyStimulus(1'b1, mk(5'd31, 3'd7, 3'd1, 1'b0, 3'd1, 1'b1, 8'h00), 1'b1, 1'b0, 3'd0, 8'h00, 8'h00,
                      ex(8'h40, 8'h33, 8'h33, 5'd10, 3'd4, 1'b1, 1'b1, 1'b0));
        // Release into a bubble
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00,
                      ex(8'h40, 8'h33, 8'h33, 5'd10, 3'd4, 1'b0, 1'b0, 1'b1));
        // r6 write made during stall is visible
        applyStimulus(1'b1, mk(5'd11, 3'd1, 3'd6, 1'b1, 3'd3, 1'b0, 8'h5A), 1'b0, 1'b0, 3'd0, 8'h00, 8'h00,
                      ex(8'h99, 8'h5A, 8'h40, 5'd11, 3'd1, 1'b0, 1'b1, 1'b1));
        applyStimulus(1'b1, mk(5'd12, 3'd2, 3'd3, 1'b0, 3'd4, 1'b1, 8'h00), 1'b0, 1'b0, 3'd0, 8'h00, 8'h00,
                      ex(8'h40, 8'hC0, 8'hC0, 5'd12, 3'd2, 1'b1, 1'b1, 1'b1));

        // Mid-operation asynchronous reset, asserted between edges
        @(posedge clk);
        #3;
        idleInputs();
        reset = 1'b0;
        #1;
        checkOutput("async_reset", ex(8'h00, 8'h00, 8'h00, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1));
        #199;
        reset = 1'b1;

        // Every register reads zero after reset
        applyStimulus(1'b1, mk(5'd1, 3'd1, 3'd3, 1'b0, 3'd4, 1'b0, 8'h00), 1'b0, 1'b0, 3'd0, 8'h00, 8'h00,
                      ex(8'h00, 8'h00, 8'h00, 5'd1, 3'd1, 1'b0, 1'b1, 1'b1));
        applyStimulus(1'b1, mk(5'd2, 3'd2, 3'd5, 1'b0, 3'd6, 1'b0, 8'h00), 1'b0, 1'b0, 3'd0, 8'h00, 8'h00,
                      ex(8'h00, 8'h00, 8'h00, 5'd2, 3'd2, 1'b0, 1'b1, 1'b1));

        @(negedge clk);
        idleInputs();
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
